// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment pair monitor: active-low digit codes
// (dp off) and the tracking FSM state type.
package seg_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic {
    ST_WAIT_FIRST = 1'b0,
    ST_TRACK      = 1'b1
  } state_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of one active-low seven-segment byte to a BCD digit.
// Anything outside the ten digit codes (including a lit dp or blank) is illegal.
module seg7_to_bcd
  import seg_pkg::*;
(
  input  logic [7:0] i_seg,
  output logic [3:0] o_digit,
  output logic       o_legal
);

  always_comb begin
    o_digit = 4'd0;
    o_legal = 1'b1;
    case (i_seg)
      SEG_0:   o_digit = 4'd0;
      SEG_1:   o_digit = 4'd1;
      SEG_2:   o_digit = 4'd2;
      SEG_3:   o_digit = 4'd3;
      SEG_4:   o_digit = 4'd4;
      SEG_5:   o_digit = 4'd5;
      SEG_6:   o_digit = 4'd6;
      SEG_7:   o_digit = 4'd7;
      SEG_8:   o_digit = 4'd8;
      SEG_9:   o_digit = 4'd9;
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_pair_monitor.sv
// Watches a two-digit seven-segment display, accepts a reading once it has been
// stable long enough, and flags undecodable pairs and breaks in the +1 sequence.
module seg_pair_monitor
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int MAX_VALUE     = 15
) (
  input  logic       clock50M,
  input  logic       reset,
  input  logic [7:0] seg1,
  input  logic [7:0] seg0,
  output logic [4:0] value,
  output logic       value_valid,
  output logic       pattern_error,
  output logic       seq_error,
  output logic [7:0] err_count
);

  logic [15:0] r_sync1, r_sync2, r_hold;
  logic [8:0]  r_cnt;
  state_t      r_state, w_state_next;
  logic [4:0]  r_value, w_value_next;
  logic        r_valid, w_valid_next;
  logic        r_perr, w_perr_next;
  logic        r_serr, w_serr_next;
  logic [7:0]  r_errcnt, w_errcnt_next;

  logic [3:0]  w_tens, w_units;
  logic        w_tens_legal, w_units_legal;
  logic [4:0]  w_dec_value, w_expect;
  logic        w_legal, w_accept;

  // Count 1..STABLE_CYCLES then park one above so each stable period accepts once.
  // A zero count (after reset) stays idle until the synchronized word changes.
  always_ff @(posedge clock50M) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_hold  <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= {seg1, seg0};
      r_sync2 <= r_sync1;
      if (r_sync2 != r_hold) begin
        r_hold <= r_sync2;
        r_cnt  <= 9'd1;
      end else if (r_cnt != 9'd0 && r_cnt <= 9'(STABLE_CYCLES)) begin
        r_cnt <= r_cnt + 9'd1;
      end
    end
  end

  assign w_accept = (r_cnt == 9'(STABLE_CYCLES));

  seg7_to_bcd u_dec_tens  (.i_seg(r_hold[15:8]), .o_digit(w_tens),  .o_legal(w_tens_legal));
  seg7_to_bcd u_dec_units (.i_seg(r_hold[7:0]),  .o_digit(w_units), .o_legal(w_units_legal));

  assign w_dec_value = 5'(w_tens) * 5'd10 + 5'(w_units);
  assign w_legal     = w_tens_legal && w_units_legal && (w_tens <= 4'd1)
                       && (w_dec_value <= 5'(MAX_VALUE));
  assign w_expect    = (r_value == 5'(MAX_VALUE)) ? 5'd0 : r_value + 5'd1;

  always_comb begin
    w_state_next = r_state;
    w_value_next = r_value;
    w_valid_next = 1'b0;
    w_perr_next  = 1'b0;
    w_serr_next  = 1'b0;
    if (w_accept) begin
      if (!w_legal) begin
        w_perr_next = 1'b1;
      end else if (r_state == ST_WAIT_FIRST) begin
        w_value_next = w_dec_value;
        w_valid_next = 1'b1;
        w_state_next = ST_TRACK;
      end else if (w_dec_value != r_value) begin
        // Out-of-sequence values still load so tracking resyncs to the display.
        w_value_next = w_dec_value;
        w_valid_next = 1'b1;
        w_serr_next  = (w_dec_value != w_expect);
      end
    end
    w_errcnt_next = r_errcnt;
    if ((w_perr_next || w_serr_next) && r_errcnt != 8'hFF)
      w_errcnt_next = r_errcnt + 8'd1;
  end

  always_ff @(posedge clock50M) begin
    if (reset) r_state <= ST_WAIT_FIRST;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clock50M) begin
    if (reset) begin
      r_value  <= '0;
      r_valid  <= 1'b0;
      r_perr   <= 1'b0;
      r_serr   <= 1'b0;
      r_errcnt <= '0;
    end else begin
      r_value  <= w_value_next;
      r_valid  <= w_valid_next;
      r_perr   <= w_perr_next;
      r_serr   <= w_serr_next;
      r_errcnt <= w_errcnt_next;
    end
  end

  assign value         = r_value;
  assign value_valid   = r_valid;
  assign pattern_error = r_perr;
  assign seq_error     = r_serr;
  assign err_count     = r_errcnt;

endmodule

// File: tb/tb_seg_pair_monitor.sv
// Scoreboard bench: each driven pair is run through a reference model and any
// expected pulse is queued; the monitor pops and compares whenever the DUT pulses.
module tb_seg_pair_monitor;

  localparam int STABLE = 4;
  localparam int MAXV   = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] seg1, seg0;
  logic [4:0] value;
  logic       value_valid, pattern_error, seq_error;
  logic [7:0] err_count;

  seg_pair_monitor #(.STABLE_CYCLES(STABLE), .MAX_VALUE(MAXV)) dut (
    .clock50M(clk), .reset(reset), .seg1(seg1), .seg0(seg0),
    .value(value), .value_valid(value_valid), .pattern_error(pattern_error),
    .seq_error(seq_error), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] value;
    logic       perr;
    logic       serr;
    logic [7:0] errcnt;
    int         cyc;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  int         n_valid = 0;
  logic [7:0] codes [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                             8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  // reference model state
  bit          m_first;
  int          m_value;
  int          m_errcnt;
  logic [15:0] m_last;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp_v, cyc);
  endtask

  function automatic int digit_of(input logic [7:0] s);
    for (int i = 0; i < 10; i++) if (codes[i] == s) return i;
    return -1;
  endfunction

  task automatic model_accept(input logic [7:0] s1, input logic [7:0] s0, input int due);
    exp_t e;
    int   t, u, v;
    bit   serr;
    t = digit_of(s1);
    u = digit_of(s0);
    v = t * 10 + u;
    e.cyc = due;
    if (t < 0 || t > 1 || u < 0 || v > MAXV) begin
      if (m_errcnt < 255) m_errcnt++;
      e.value = 5'(m_value); e.perr = 1'b1; e.serr = 1'b0; e.errcnt = 8'(m_errcnt);
      q.push_back(e);
    end else if (m_first) begin
      m_first = 1'b0;
      m_value = v;
      e.value = 5'(v); e.perr = 1'b0; e.serr = 1'b0; e.errcnt = 8'(m_errcnt);
      q.push_back(e);
    end else if (v != m_value) begin
      serr = (v != ((m_value + 1) % (MAXV + 1)));
      if (serr && m_errcnt < 255) m_errcnt++;
      m_value = v;
      e.value = 5'(v); e.perr = 1'b0; e.serr = serr; e.errcnt = 8'(m_errcnt);
      q.push_back(e);
    end
  endtask

  // Drive a pair for `hold` cycles; the first edge sampling it is one edge
  // after the drive, so any pulse is due 2+STABLE edges after that one.
  task automatic apply(input logic [7:0] s1, input logic [7:0] s0, input int hold);
    @(posedge clk); #1;
    seg1 = s1;
    seg0 = s0;
    if (hold >= STABLE && {s1, s0} != m_last) model_accept(s1, s0, cyc + 3 + STABLE);
    m_last = {s1, s0};
    repeat (hold - 1) @(posedge clk);
  endtask

  task automatic apply_value(input int v, input int hold);
    logic [7:0] s1, s0;
    s1 = codes[v / 10];
    s0 = codes[v % 10];
    apply(s1, s0, hold);
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    reset = 1'b1;
    m_first = 1'b1; m_value = 0; m_errcnt = 0; m_last = 16'h0000;
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && (value_valid || pattern_error || seq_error)) begin
      if (q.size() == 0) begin
        check("spurious_pulse", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        $display("event cyc=%0d value=%0d valid=%0b perr=%0b serr=%0b errcnt=%0d",
                 cyc, value, value_valid, pattern_error, seq_error, err_count);
        check("value", 32'(value), 32'(e.value));
        check("value_valid", 32'(value_valid), 32'(!e.perr));
        check("pattern_error", 32'(pattern_error), 32'(e.perr));
        check("seq_error", 32'(seq_error), 32'(e.serr));
        check("err_count", 32'(err_count), 32'(e.errcnt));
        check("latency_cycle", 32'(cyc), 32'(e.cyc));
        if (value_valid) n_valid++;
      end
    end
  end

  initial begin
    reset = 1'b1;
    seg1 = 8'hFF;
    seg0 = 8'hFF;
    m_first = 1'b1; m_value = 0; m_errcnt = 0; m_last = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_value", 32'(value), 32'd0);
    check("rst_valid", 32'(value_valid), 32'd0);
    check("rst_perr", 32'(pattern_error), 32'd0);
    check("rst_serr", 32'(seq_error), 32'd0);
    check("rst_errcnt", 32'(err_count), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // first value, then full count with wrap
    apply(8'hC0, 8'hC0, 20);
    for (int v = 1; v <= MAXV; v++) apply_value(v, 20);
    apply_value(0, 20);
    @(negedge clk);
    check("wrap_valid_count", 32'(n_valid), 32'd17);
    check("wrap_err_count", 32'(err_count), 32'd0);

    // sequence break 3 -> 5
    for (int v = 1; v <= 3; v++) apply_value(v, 20);
    apply(8'hC0, 8'h92, 20);

    // undecodable and out-of-range pairs, then a short glitch
    apply(8'hC0, 8'hFF, 20);
    apply(8'hA4, 8'hC0, 20);
    apply(8'hC0, 8'h99, 20);
    apply(8'hC0, 8'h82, 3);
    apply(8'hC0, 8'h99, 20);

    // saturate the error counter
    for (int i = 0; i < 300; i++) apply(8'hC0, (i % 2 == 0) ? 8'hFE : 8'hFF, 8);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("err_count_saturated", 32'(err_count), 32'd255);

    // reset in the middle of a stable count, then a fresh first value
    apply(8'hC0, 8'h92, 3);
    do_reset(2);
    @(negedge clk);
    check("rst2_errcnt", 32'(err_count), 32'd0);
    check("rst2_value", 32'(value), 32'd0);
    apply(8'hF9, 8'hC0, 20);
    @(negedge clk);
    check("after_rst_value", 32'(value), 32'd10);

    repeat (10) @(posedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg_pair_monitor.md
SEG_PAIR_MONITOR -- requirements
Module: seg_pair_monitor

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, sets the consecutive cycles a segment pair must hold before acceptance; legal range 2..255.
REQ-002 Parameter MAX_VALUE, default 15, sets the highest legal decoded value and the sequence wrap point; legal range 1..19.
REQ-003 Port clock50M, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port seg1, input, 8 bits: tens-digit segment pattern, asynchronous to clock50M.
REQ-006 Port seg0, input, 8 bits: units-digit segment pattern, asynchronous to clock50M.
REQ-007 Port value, output, 5 bits: last accepted decoded value, tens*10+units.
REQ-008 Port value_valid, output, 1 bit: one-cycle pulse when value updates.
REQ-009 Port pattern_error, output, 1 bit: one-cycle pulse when an accepted pair fails to decode.
REQ-010 Port seq_error, output, 1 bit: one-cycle pulse when an accepted value breaks the +1 sequence.
REQ-011 Port err_count, output, 8 bits: saturating count of pattern_error plus seq_error events.

Function
REQ-012 Segment encoding is active-low, bit7 = dp, bits 6..0 = g,f,e,d,c,b,a; dp must be 1 (off).
REQ-013 Legal digit codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex); any other byte is illegal.
REQ-014 seg1 is legal only for codes 0 or 1; decoded value above MAX_VALUE is illegal.
REQ-015 seg1 and seg0 pass through a two-flop synchronizer as one 16-bit word.
REQ-016 The synchronized word is accepted once it has held identical for STABLE_CYCLES consecutive cycles; any change restarts the count.
REQ-017 Each stable period yields at most one acceptance; re-acceptance requires a change and a new stable period.
REQ-018 Latency: value_valid or error pulse asserts exactly 2+STABLE_CYCLES cycles after the first edge sampling the new inputs (6 at default).
REQ-019 FSM WAIT_FIRST: first legal acceptance loads value, pulses value_valid, no sequence check, moves to TRACK.
REQ-020 FSM TRACK: legal acceptance equal to value produces no pulse; different legal value loads value and pulses value_valid.
REQ-021 In TRACK, a new legal value not equal to (value+1) modulo (MAX_VALUE+1) also pulses seq_error in the same cycle; value still loads (resync).
REQ-022 Wrap MAX_VALUE -> 0 is a correct step, no seq_error.
REQ-023 Illegal acceptance in either state pulses pattern_error, leaves value and state unchanged.
REQ-024 err_count increments by 1 per error cycle (pattern_error and seq_error are mutually exclusive) and saturates at 255.

Reset
REQ-025 With reset high at a clock edge: value=0, value_valid=0, pattern_error=0, seq_error=0, err_count=0, state=WAIT_FIRST, synchronizer and stability counter cleared.
REQ-026 Reset mid stable period discards the partial count; the following acceptance after release counts as first value.
REQ-027 Outputs are registered; no output depends combinationally on seg1/seg0.

Structure
REQ-028 Package seg_pkg holds the ten segment constants, blank code FF, and the FSM state type.
REQ-029 Sub-module seg7_to_bcd (combinational, byte in, 4-bit digit plus legal flag out) is instantiated twice.

Verification
REQ-030 Reset, then hold seg1=C0, seg0=C0 -> value_valid pulses at cycle 6, value=0, no errors.
REQ-031 Step 0..15 then 0 with 20-cycle holds -> 17 value_valid pulses, wrap 15->0 clean, err_count=0.
REQ-032 From value=3 apply C0/92 (5) -> value_valid and seq_error same cycle, value=5, err_count=1.
REQ-033 Apply seg0=FF, or seg1=A4 (20) -> pattern_error pulse, value unchanged; 3-cycle glitch to 82 between holds of 99 -> no pulse.
REQ-034 Force 300 error events -> err_count holds 255.
REQ-035 Assert reset during stable count then present F9/C0 -> value=10 accepted as first value, no seq_error.
